// File: rtl/bs_engine_dispatcher.sv
// Queues tagged option-pricing requests, hands each to the lowest-index idle engine,
// and funnels the (possibly out-of-order) engine results into a tagged response stream.
module bs_engine_dispatcher #(
  parameter int DATA_W      = 16,
  parameter int NUM_ENG     = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int TAG_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [DATA_W-1:0]            req_S,
  input  logic [DATA_W-1:0]            req_K,
  input  logic [DATA_W-1:0]            req_r,
  input  logic [DATA_W-1:0]            req_sigma,
  input  logic [DATA_W-1:0]            req_T,
  input  logic [TAG_W-1:0]             req_tag,
  output logic [NUM_ENG-1:0]           eng_start,
  output logic [NUM_ENG*DATA_W-1:0]    eng_S,
  output logic [NUM_ENG*DATA_W-1:0]    eng_K,
  output logic [NUM_ENG*DATA_W-1:0]    eng_r,
  output logic [NUM_ENG*DATA_W-1:0]    eng_sigma,
  output logic [NUM_ENG*DATA_W-1:0]    eng_T,
  input  logic [NUM_ENG-1:0]           eng_done,
  input  logic [NUM_ENG*DATA_W-1:0]    eng_price,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_price,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [$clog2(NUM_ENG+1)-1:0] busy_count,
  output logic                         err_spurious
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int BW = $clog2(NUM_ENG + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] sigma;
    logic [DATA_W-1:0] t;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] price;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  typedef enum logic [1:0] {ENG_IDLE, ENG_RUN, ENG_HOLD} eng_state_e;

  req_t              reqMemQ [QUEUE_DEPTH];
  logic [AW-1:0]     reqWrPtrQ, reqRdPtrQ;
  logic [CW-1:0]     reqCntQ, reqCntD;
  logic              reqReadyQ;
  rsp_t              rspMemQ [QUEUE_DEPTH];
  logic [AW-1:0]     rspWrPtrQ, rspRdPtrQ;
  logic [CW-1:0]     rspCntQ, rspCntD;

  eng_state_e        stateQ [NUM_ENG];
  eng_state_e        stateD [NUM_ENG];
  req_t              engOpQ [NUM_ENG];
  logic [DATA_W-1:0] priceQ [NUM_ENG];
  logic [NUM_ENG-1:0] engStartQ, engStartD;
  logic [EW-1:0]     rrQ, rrD;
  logic [BW-1:0]     busyQ, busyD;
  logic              errQ, errD;

  logic              reqPush, rspPop, dispValid, drainValid;
  logic [EW-1:0]     dispSel, drainSel, idxE;
  req_t              reqIn;

  assign reqIn   = {req_S, req_K, req_r, req_sigma, req_T, req_tag};
  assign reqPush = req_valid && reqReadyQ;
  assign rspPop  = (rspCntQ != '0) && rsp_ready;

  // Descending scans let the lowest index (or the one nearest the pointer) win.
  always_comb begin
    dispValid  = 1'b0;
    dispSel    = '0;
    drainValid = 1'b0;
    drainSel   = '0;
    idxE       = '0;
    for (int i = NUM_ENG-1; i >= 0; i--) begin
      if (reqCntQ != '0 && stateQ[i] == ENG_IDLE) begin
        dispValid = 1'b1;
        dispSel   = EW'(i);
      end
    end
    for (int k = NUM_ENG-1; k >= 0; k--) begin
      idxE = EW'((int'(rrQ) + k) % NUM_ENG);
      if (rspCntQ != FULL_CNT && stateQ[idxE] == ENG_HOLD) begin
        drainValid = 1'b1;
        drainSel   = idxE;
      end
    end
  end

  always_comb begin
    errD      = errQ;
    engStartD = '0;
    rrD       = rrQ;
    busyD     = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      stateD[i] = stateQ[i];
      case (stateQ[i])
        ENG_IDLE: if (dispValid && dispSel == EW'(i)) stateD[i] = ENG_RUN;
        ENG_RUN:  if (eng_done[i]) stateD[i] = ENG_HOLD;
        ENG_HOLD: if (drainValid && drainSel == EW'(i)) stateD[i] = ENG_IDLE;
        default:  stateD[i] = ENG_IDLE;
      endcase
      if (eng_done[i] && stateQ[i] != ENG_RUN) errD = 1'b1;
      if (dispValid && dispSel == EW'(i)) engStartD[i] = 1'b1;
      if (stateD[i] != ENG_IDLE) busyD = busyD + BW'(1);
    end
    if (drainValid) rrD = EW'((int'(drainSel) + 1) % NUM_ENG);
    reqCntD = reqCntQ + CW'(reqPush) - CW'(dispValid);
    rspCntD = rspCntQ + CW'(drainValid) - CW'(rspPop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < QUEUE_DEPTH; d++) begin
        reqMemQ[d] <= '0;
        rspMemQ[d] <= '0;
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        stateQ[i] <= ENG_IDLE;
        engOpQ[i] <= '0;
        priceQ[i] <= '0;
      end
      reqWrPtrQ <= '0;
      reqRdPtrQ <= '0;
      reqCntQ   <= '0;
      reqReadyQ <= 1'b0;
      rspWrPtrQ <= '0;
      rspRdPtrQ <= '0;
      rspCntQ   <= '0;
      engStartQ <= '0;
      rrQ       <= '0;
      busyQ     <= '0;
      errQ      <= 1'b0;
    end else begin
      reqCntQ   <= reqCntD;
      reqReadyQ <= (reqCntD != FULL_CNT);
      rspCntQ   <= rspCntD;
      engStartQ <= engStartD;
      rrQ       <= rrD;
      busyQ     <= busyD;
      errQ      <= errD;
      if (reqPush) begin
        reqMemQ[reqWrPtrQ] <= reqIn;
        reqWrPtrQ          <= reqWrPtrQ + AW'(1);
      end
      if (dispValid) begin
        engOpQ[dispSel] <= reqMemQ[reqRdPtrQ];
        reqRdPtrQ       <= reqRdPtrQ + AW'(1);
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        stateQ[i] <= stateD[i];
        if (stateQ[i] == ENG_RUN && eng_done[i]) priceQ[i] <= eng_price[i*DATA_W +: DATA_W];
      end
      if (drainValid) begin
        rspMemQ[rspWrPtrQ] <= {priceQ[drainSel], engOpQ[drainSel].tag};
        rspWrPtrQ          <= rspWrPtrQ + AW'(1);
      end
      if (rspPop) rspRdPtrQ <= rspRdPtrQ + AW'(1);
    end
  end

  assign req_ready    = reqReadyQ;
  assign eng_start    = engStartQ;
  assign rsp_valid    = (rspCntQ != '0);
  assign rsp_price    = rspMemQ[rspRdPtrQ].price;
  assign rsp_tag      = rspMemQ[rspRdPtrQ].tag;
  assign busy_count   = busyQ;
  assign err_spurious = errQ;

  for (genvar g = 0; g < NUM_ENG; g++) begin : gEngOut
    assign eng_S[g*DATA_W +: DATA_W]     = engOpQ[g].s;
    assign eng_K[g*DATA_W +: DATA_W]     = engOpQ[g].k;
    assign eng_r[g*DATA_W +: DATA_W]     = engOpQ[g].r;
    assign eng_sigma[g*DATA_W +: DATA_W] = engOpQ[g].sigma;
    assign eng_T[g*DATA_W +: DATA_W]     = engOpQ[g].t;
  end
endmodule
